// File: rtl/tcdm_sim_ctrl_pkg.sv
// Shared definitions for the simulation-control TCDM peripheral: register map,
// STATUS bit positions and the decoded register selection.
package tcdm_sim_ctrl_pkg;

  localparam logic [7:0] EXIT_OFF   = 8'h00;
  localparam logic [7:0] PUTC_OFF   = 8'h04;
  localparam logic [7:0] CYC_LO_OFF = 8'h08;
  localparam logic [7:0] CYC_HI_OFF = 8'h0C;
  localparam logic [7:0] STATUS_OFF = 8'h10;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_EXIT_BIT  = 2;

  typedef enum logic [2:0] {
    SEL_EXIT,
    SEL_PUTC,
    SEL_CYC_LO,
    SEL_CYC_HI,
    SEL_STATUS,
    SEL_NONE
  } reg_sel_e;

  // Maps a word offset (add[7:2]) to a register; anything unlisted is unmapped.
  function automatic reg_sel_e decode_offset(input logic [5:0] word_off);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (word_off == EXIT_OFF[7:2])   sel = SEL_EXIT;
    if (word_off == PUTC_OFF[7:2])   sel = SEL_PUTC;
    if (word_off == CYC_LO_OFF[7:2]) sel = SEL_CYC_LO;
    if (word_off == CYC_HI_OFF[7:2]) sel = SEL_CYC_HI;
    if (word_off == STATUS_OFF[7:2]) sel = SEL_STATUS;
    return sel;
  endfunction

endpackage

// File: rtl/sim_char_fifo.sv
// Parametric synchronous FIFO for the character stream; DEPTH must be a power
// of two so the pointers wrap naturally.
module sim_char_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : r_mem[r_rd_ptr];

  // NOTE: storage has no reset; emptiness is tracked by r_count and data_o is
  // masked while empty, so resetting the array would only cost flops.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  // NOTE: every sequential assignment is non-blocking so all registers sample
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tcdm_sim_ctrl_periph.sv
// TCDM responder for the simulation-control window: exit-code latch, character
// output FIFO, free-running cycle counter and status, single-cycle responses.
module tcdm_sim_ctrl_periph
  import tcdm_sim_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] add_i,
  input  logic        wen_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] data_i,
  output logic [31:0] r_data_o,
  output logic        r_valid_o,
  output logic [7:0]  char_o,
  output logic        char_valid_o,
  input  logic        char_ready_i,
  output logic        exit_valid_o,
  output logic [31:0] exit_code_o,
  output logic [63:0] cycles_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  reg_sel_e         w_sel;
  logic             w_in_window;
  logic             w_putc_push_req;
  logic             w_push;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic [31:0]      w_rdata;
  logic             w_unused_addr;

  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_exit_valid;
  logic [31:0] r_exit_code;
  logic [63:0] r_cycles;
  logic [31:0] r_cyc_hi_shadow;

  // Word-aligned decode: the byte lane bits do not select a register.
  assign w_unused_addr = ^add_i[1:0];

  assign w_in_window     = (add_i[31:8] == BASE_ADDR[31:8]);
  assign w_sel           = w_in_window ? decode_offset(add_i[7:2]) : SEL_NONE;
  assign w_putc_push_req = req_i && !wen_i && (w_sel == SEL_PUTC) && be_i[0];

  // Only a real character push can stall; it waits for the FIFO state at the
  // start of the cycle, so a concurrent pop releases it one cycle later.
  assign gnt_o  = req_i && !rst_i && !(w_putc_push_req && w_fifo_full);
  assign w_push = gnt_o && w_putc_push_req;

  sim_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_char_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (data_i[7:0]),
    .pop_i   (char_ready_i),
    .data_o  (char_o),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  // NOTE: w_rdata gets its default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_rdata = UNMAPPED_RDATA;
    unique case (w_sel)
      SEL_EXIT:   w_rdata = r_exit_code;
      SEL_PUTC:   w_rdata = 32'(w_fifo_count);
      SEL_CYC_LO: w_rdata = r_cycles[31:0];
      SEL_CYC_HI: w_rdata = r_cyc_hi_shadow;
      SEL_STATUS: begin
        w_rdata                   = '0;
        w_rdata[STATUS_FULL_BIT]  = w_fifo_full;
        w_rdata[STATUS_EMPTY_BIT] = w_fifo_empty;
        w_rdata[STATUS_EXIT_BIT]  = r_exit_valid;
      end
      default:    w_rdata = UNMAPPED_RDATA;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid        <= 1'b0;
      r_rdata         <= '0;
      r_exit_valid    <= 1'b0;
      r_exit_code     <= '0;
      r_cycles        <= '0;
      r_cyc_hi_shadow <= '0;
    end else begin
      r_rvalid <= gnt_o;
      if (gnt_o) r_rdata <= wen_i ? w_rdata : 32'h0;
      if (gnt_o && wen_i && (w_sel == SEL_CYC_LO)) r_cyc_hi_shadow <= r_cycles[63:32];
      if (gnt_o && !wen_i && (w_sel == SEL_EXIT) && (be_i == 4'hF) && !r_exit_valid) begin
        r_exit_valid <= 1'b1;
        r_exit_code  <= data_i;
      end
      // The edge that latches the exit code still counts; later edges do not.
      if (!r_exit_valid) r_cycles <= r_cycles + 64'd1;
    end
  end

  assign r_valid_o    = r_rvalid;
  assign r_data_o     = r_rdata;
  assign char_valid_o = !w_fifo_empty;
  assign exit_valid_o = r_exit_valid;
  assign exit_code_o  = r_exit_code;
  assign cycles_o     = r_cycles;

endmodule

// File: doc/tcdm_sim_ctrl_periph.md
Name: tcdm_sim_ctrl_periph

Overview:
- Synthesizable TCDM-style responder for core data-port accesses in the 0x8000_0000 simulation-control window.
- Replaces the bench's ad-hoc rvalid and address snooping with a proper target.
- Accepts exit-code writes and character writes, and exposes a free-running cycle counter and status to software.
- Streams characters through a small FIFO to a ready/valid sink, such as a bench $write monitor or a UART model.

Parameters:
- BASE_ADDR, 32'h8000_0000, base of the 256-byte register window; add_i[31:8] must equal BASE_ADDR[31:8].
- FIFO_DEPTH, 8, character FIFO depth; power of two, ≥2.
- UNMAPPED_RDATA, 32'hDEAD_BEEF, read data returned for unmapped offsets.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  1  TCDM request
- gnt_o  out  1  TCDM grant
- add_i  in  32  byte address
- wen_i  in  1  1 = read, 0 = write (TCDM convention)
- be_i  in  4  byte enables
- data_i  in  32  write data
- r_data_o  out  32  read data
- r_valid_o  out  1  response valid
- char_o  out  8  character to sink
- char_valid_o  out  1  character available
- char_ready_i  in  1  sink accepts character
- exit_valid_o  out  1  exit code has been written (sticky)
- exit_code_o  out  32  latched exit code
- cycles_o  out  64  current cycle count

Behaviour:
- Reset (asynchronous on rst_i high) clears all state and outputs:
  - gnt_o, r_valid_o, char_valid_o and exit_valid_o are 0.
  - r_data_o, exit_code_o, cycles_o and char_o are 0.
  - The FIFO is empty.
  - Reset mid-transaction drops any pending response.
- Register map, word offsets add_i[7:2]:
  - 0x00 EXIT. Write with be_i==4'hF latches data_i into exit_code_o and sets exit_valid_o. Once exit_valid_o is set, later writes are ignored until reset. A write with any other be_i is ignored. Read returns exit_code_o.
  - 0x04 PUTC. Write with be_i[0]=1 pushes data_i[7:0] into the FIFO. Write with be_i[0]=0 is a no-op but is still granted. Read returns the zero-extended FIFO occupancy.
  - 0x08 CYC_LO. Read returns cycles[31:0] and snapshots cycles[63:32] into a shadow register.
  - 0x0C CYC_HI. Read returns the shadow register.
  - 0x10 STATUS, read-only. bit0 = FIFO full, bit1 = FIFO empty, bit2 = exit_valid. Other bits read 0.
  - Any other offset, or add_i[31:8] not matching the base: reads return UNMAPPED_RDATA and writes are dropped. Both are still granted.
- Grant rule:
  - gnt_o is combinational.
  - gnt_o = req_i, except gnt_o = 0 for a write to PUTC with be_i[0]=1 while the FIFO is full.
  - A pop in the same cycle does not un-stall that cycle; the grant follows next cycle.
  - The requester holds req_i and its payload until granted.
- Response:
  - Every granted request, read or write, produces r_valid_o=1 exactly one cycle later, for exactly one cycle.
  - r_data_o is registered and valid with r_valid_o. It is 0 for writes and holds its value otherwise.
  - Back-to-back granted requests give back-to-back responses, with no bubbles.
- Cycle counter:
  - 64-bit, increments every cycle after reset and wraps at 2^64−1 to 0.
  - Freezes the cycle after exit_valid_o rises.
  - cycles_o is the live counter value.
- Character output:
  - char_o is the FIFO head and char_valid_o = FIFO not empty.
  - A pop happens when char_valid_o && char_ready_i.
  - A push and a pop in the same cycle on a non-full FIFO leave occupancy unchanged and keep order.
  - Occupancy counter is log2(FIFO_DEPTH)+1 bits wide; pointers wrap modulo FIFO_DEPTH.
- Simultaneous-event priority: reset > exit latch > counter freeze. An EXIT write and a CYC_LO read cannot coincide because there is a single port.

Decomposition:
- tcdm_sim_ctrl_pkg holds:
  - register offset localparams (EXIT_OFF, PUTC_OFF, CYC_LO_OFF, CYC_HI_OFF, STATUS_OFF);
  - STATUS bit indices;
  - an enum for the decoded register selection.
- One sub-module, sim_char_fifo: a parametric synchronous FIFO with push/pop/full/empty/count ports.
- The top level does address decode, grant, response registering, the counter and the exit latch.

Test Plan:
1. Reset then idle, 10 cycles: all outputs 0 during reset. After release, the CYC_LO read issued at cycle 10 returns 10±1, and CYC_HI returns 0.
2. Write PUTC with 0x48 then 0x69, char_ready_i held at 1: both writes granted in the request cycle with r_valid_o one cycle later. char_o shows 0x48 then 0x69, each with char_valid_o for 1 cycle.
3. char_ready_i=0, issue 9 PUTC writes with FIFO_DEPTH=8: the first 8 are granted, the 9th has gnt_o=0 and STATUS reads 0x1. Raise char_ready_i for 1 cycle: the 9th is granted the following cycle and the FIFO returns 0x41..0x48 in order.
4. Write EXIT 0x0000_0000, then EXIT 0x0000_0005: exit_valid_o=1 and exit_code_o stays 0. The cycle counter read at the next cycle equals the value read 100 cycles later. STATUS bit2=1.
5. Read 0x8000_0040, then write 0x8000_0040 with 0x1234: the read returns 0xDEAD_BEEF and the write gets r_valid_o with no state change (EXIT, FIFO and STATUS unchanged).
6. Assert rst_i for 1 cycle while a read is outstanding and 3 characters are queued: no r_valid_o after reset, the FIFO is empty and cycles_o restarts from 0.
